// File: rtl/rotate_arbiter_16_pkg.sv
// ============================================================================
// Module  : rotate_arbiter_16_pkg
// Brief   : Shared op codes, widths, state encodings and fill-mask helper
//           for the shared rotate/shift datapath.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rotate_arbiter_16_pkg;

    localparam int SH_W  = 16;
    localparam int SH_AW = 4;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_LSR = 2'b10,
        OP_ASR = 2'b11
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Top 'amt' bits set; these are the positions a logical/arithmetic shift refills.
    function automatic logic [SH_W-1:0] fill_mask(input logic [SH_AW-1:0] amt);
        return ~({SH_W{1'b1}} >> amt);
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shifter_16.sv
// ============================================================================
// Module  : barrel_shifter_16
// Brief   : 16-bit rotate-right core, y[i] = a[(i+s) mod 16].
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_shifter_16
    import rotate_arbiter_16_pkg::*;
(
    input  logic [SH_W-1:0]  a,
    input  logic [SH_AW-1:0] s,
    output logic [SH_W-1:0]  y
);

    logic [SH_W-1:0] w_t;

    // Log-depth: stage k rotates by 2**k when s[k] is set.
    always_comb begin
        w_t = a;
        for (int k = 0; k < SH_AW; k++) begin
            if (s[k]) begin
                w_t = (w_t >> (1 << k)) | (w_t << (SH_W - (1 << k)));
            end
        end
    end

    assign y = w_t;

endmodule

`default_nettype wire

// File: rtl/rotate_arbiter_16.sv
// ============================================================================
// Module  : rotate_arbiter_16
// Brief   : Round-robin share of one barrel_shifter_16 between two requesters,
//           with a registered valid/ready result port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rotate_arbiter_16
    import rotate_arbiter_16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SH_W-1:0]  req0_data,
    input  logic [SH_AW-1:0] req0_amt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SH_W-1:0]  req1_data,
    input  logic [SH_AW-1:0] req1_amt,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SH_W-1:0]  res_data,
    output logic             res_id,
    output logic             res_zero
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_last_grant;
    logic [SH_W-1:0]  r_res_data;
    logic             r_res_id;
    logic             r_res_zero;

    logic             w_can_accept;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_sel;
    logic [SH_W-1:0]  w_opnd;
    logic [SH_AW-1:0] w_amt;
    op_e              w_op;
    logic [SH_AW-1:0] w_shamt;
    logic [SH_W-1:0]  w_rot;
    logic [SH_W-1:0]  w_mask;
    logic [SH_W-1:0]  w_result;

    // Readies are held low while reset is asserted, whatever state is held.
    assign w_can_accept = ~reset & ((r_state == ST_IDLE) |
                                    ((r_state == ST_RESP) & res_ready));

    assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

    assign req0_ready = w_can_accept & w_gnt0;
    assign req1_ready = w_can_accept & w_gnt1;
    assign w_accept   = req0_ready | req1_ready;
    assign w_sel      = w_gnt1;

    assign w_opnd = w_sel ? req1_data : req0_data;
    assign w_amt  = w_sel ? req1_amt  : req0_amt;
    assign w_op   = op_e'(w_sel ? req1_op : req0_op);

    // Rotate-left by n is rotate-right by (16-n) mod 16.
    assign w_shamt = (w_op == OP_ROL) ? (4'd0 - w_amt) : w_amt;
    assign w_mask  = fill_mask(w_amt);

    barrel_shifter_16 u_rot (
        .a (w_opnd),
        .s (w_shamt),
        .y (w_rot)
    );

    always_comb begin
        w_result = w_rot;
        case (w_op)
            OP_LSR:  w_result = w_rot & ~w_mask;
            OP_ASR:  w_result = w_opnd[SH_W-1] ? (w_rot | w_mask) : (w_rot & ~w_mask);
            default: w_result = w_rot;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RESP;
            ST_RESP: if (res_ready && !w_accept) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_res_data   <= '0;
            r_res_id     <= 1'b0;
            r_res_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_res_data   <= w_result;
                r_res_id     <= w_sel;
                r_res_zero   <= (w_result == '0);
                r_last_grant <= w_sel;
            end
        end
    end

    assign res_valid = (r_state == ST_RESP);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign res_zero  = r_res_zero;

endmodule

`default_nettype wire

// File: tb/tb_rotate_arbiter_16.sv
// ============================================================================
// Module  : tb_rotate_arbiter_16
// Brief   : Scoreboard bench for rotate_arbiter_16 with a behavioural model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rotate_arbiter_16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic [3:0]  req0_amt = '0, req1_amt = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic        res_valid, res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_id, res_zero;

    rotate_arbiter_16 dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;

    logic        pv[2];
    logic [15:0] pd[2];
    logic [3:0]  pa[2];
    logic [1:0]  po[2];
    logic [15:0] pe[2];
    logic        m_lg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int amt, input logic [1:0] op);
        logic [15:0] y;
        logic [31:0] t;
        y = '0;
        case (op)
            2'b00: for (int i = 0; i < 16; i++) y[i] = d[(i + amt) % 16];
            2'b01: begin t = {d, d} << amt; y = t[31:16]; end
            2'b10: y = d >> amt;
            default: y = 16'($signed(d) >>> amt);
        endcase
        return y;
    endfunction

    task automatic drive();
        req0_valid = pv[0]; req0_data = pd[0]; req0_amt = pa[0]; req0_op = po[0];
        req1_valid = pv[1]; req1_data = pd[1]; req1_amt = pa[1]; req1_op = po[1];
    endtask

    // One clock cycle: entered just after a falling edge with pending state and
    // res_ready set; predicts the grant, checks readies, records accepted op.
    task automatic step();
        logic can, any, g;
        exp_t e;
        drive();
        #3;
        can = (sbq.size() == 0) || res_ready;
        any = pv[0] || pv[1];
        if (pv[0] && pv[1]) g = ~m_lg;
        else g = pv[1];
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, can && any && !g});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, can && any && g});
        @(posedge clk);
        #1;
        if (can && any) begin
            e.id = g;
            e.data = pe[g];
            sbq.push_back(e);
            m_lg = g;
            pv[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        res_ready = 1'b0;
        drive();
        #3;
        chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        sbq.delete();
        m_lg = 1'b1;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", {16'b0, res_data}, 32'd0);
        chk("rst_res_id", {31'b0, res_id}, 32'd0);
        chk("rst_res_zero", {31'b0, res_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [15:0] d, input logic [3:0] a,
                           input logic [1:0] op, input logic [15:0] ev);
        pv[p] = 1'b1; pd[p] = d; pa[p] = a; po[p] = op; pe[p] = ev;
    endtask

    task automatic set_rand(input int p);
        logic [15:0] d;
        logic [3:0]  a;
        logic [1:0]  op;
        d = 16'($urandom);
        a = 4'($urandom);
        op = 2'($urandom);
        if ($urandom_range(0, 7) == 0) d = 16'h0000;
        set_req(p, d, a, op, ref_shift(d, int'(a), op));
    endtask

    task automatic issue(input int p, input logic [15:0] d, input logic [3:0] a,
                         input logic [1:0] op, input logic [15:0] ev);
        int n;
        set_req(p, d, a, op, ev);
        n = 0;
        while (pv[p] && n < 20) begin
            step();
            n++;
        end
        chk("issue_timeout", {31'b0, pv[p]}, 32'd0);
        pv[p] = 1'b0;
    endtask

    // Monitor: one tick before each rising edge, compare the held result
    // against the scoreboard head and retire it on a handshake.
    always @(negedge clk) begin
        #4;
        if (!reset) begin
            chk("res_valid", {31'b0, res_valid}, {31'b0, sbq.size() != 0});
            if (res_valid && sbq.size() != 0) begin
                chk("res_data", {16'b0, res_data}, {16'b0, sbq[0].data});
                chk("res_id", {31'b0, res_id}, {31'b0, sbq[0].id});
                chk("res_zero", {31'b0, res_zero}, {31'b0, sbq[0].data == 16'h0});
                if (res_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pd[p] = '0; pa[p] = '0; po[p] = '0; pe[p] = '0;
        end
        m_lg = 1'b1;
        @(negedge clk);
        do_reset();

        // Directed op cases
        res_ready = 1'b1;
        issue(0, 16'h1234, 4'd4,  2'b00, 16'h4123);
        issue(1, 16'h1234, 4'd4,  2'b01, 16'h2341);
        issue(1, 16'h1234, 4'd0,  2'b01, 16'h1234);
        issue(0, 16'h8001, 4'd1,  2'b10, 16'h4000);
        issue(0, 16'h8000, 4'd15, 2'b11, 16'hFFFF);
        issue(1, 16'h7FFF, 4'd15, 2'b11, 16'h0000);
        step();

        // Both requesters busy every cycle: alternating grants
        for (int c = 0; c < 8; c++) begin
            if (!pv[0]) set_rand(0);
            if (!pv[1]) set_rand(1);
            step();
        end
        pv[0] = 1'b0; pv[1] = 1'b0;
        step();

        // Back-pressure: result held for 3 cycles, then new accept on release
        issue(0, 16'h00F0, 4'd4, 2'b00, 16'h000F);
        res_ready = 1'b0;
        set_req(0, 16'hA5A5, 4'd8, 2'b00, 16'hA5A5);
        for (int c = 0; c < 3; c++) step();
        res_ready = 1'b1;
        step();
        chk("release_accept", {31'b0, pv[0]}, 32'd0);
        step();

        // Reset while holding a result with req1 waiting
        issue(1, 16'h0003, 4'd1, 2'b10, 16'h0001);
        res_ready = 1'b0;
        set_req(1, 16'h1111, 4'd1, 2'b01, 16'h2222);
        step();
        do_reset();
        res_ready = 1'b1;
        set_req(0, 16'h0001, 4'd1, 2'b00, 16'h8000);
        step();
        chk("post_reset_grant0", {31'b0, pv[0]}, 32'd0);
        step();

        // Randomised traffic with random back-pressure
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(0, 2) != 0) set_rand(p);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain
        pv[0] = 1'b0; pv[1] = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("drain_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
